imem_loader: RTL and testbench

- Byte-stream boot loader that writes the instruction memory and holds the processor core in reset until loading is complete.
- Accepts a little-endian image over a valid/ready byte interface: 8-byte start PC, 4-byte word count N, then N 32-bit instructions.
- Writes each instruction word to the instruction-memory write port, then releases the core's active-low reset and presents the start PC.
- Sits between the host/boot link and the core's `resetl`/`startpc` inputs.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader for the instruction memory
//
// Receives a little-endian boot image (8-byte start PC, 4-byte word count N,
// N 32-bit words), writes each word to the instruction memory and then
// releases the core from reset with the captured start PC.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte covering every preceding stream byte.
//
// Ports:
//   CLK           clock, rising edge
//   reset         asynchronous active-high reset
//   in_valid      stream byte valid
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle
//   imem_wr_en    one-cycle instruction-memory write strobe
//   imem_wr_addr  byte address of the write
//   imem_wr_data  instruction word to write
//   startpc       start PC from the header
//   proc_resetl   core reset, active-low
//   busy          load in progress
//   error         sticky error flag
//   words_loaded  words written so far
module imem_loader #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_wr_en,
  output logic [63:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic [63:0] startpc,
  output logic        proc_resetl,
  output logic        busy,
  output logic        error,
  output logic [31:0] words_loaded
);

  typedef enum logic [2:0] {
    HDR_PC,
    HDR_CNT,
    DATA,
    DRAIN,
    RUN,
    ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  // State entered once the payload (or a zero count) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHK;
`else
  localparam state_t END_STATE = DRAIN;
`endif

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q;
  logic [31:0] word_idx_q;
  logic [31:0] count_q;
  // Shared assembly register: bytes enter at the top and shift down, so a
  // complete 8-byte field sits in [63:0] and a 4-byte field in [63:32].
  logic [63:0] acc_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xsum_q;
`endif

  logic        fire;
  logic        item_last;
  logic        ready_d;
  logic [63:0] acc_next;

  always_comb begin
    fire      = in_valid && in_ready;
    acc_next  = {in_data, acc_q[63:8]};
    item_last = (state_q == HDR_PC) ? (byte_cnt_q == 3'd7) : (byte_cnt_q == 3'd3);
    state_d   = state_q;
    case (state_q)
      HDR_PC: if (fire && item_last) state_d = HDR_CNT;
      HDR_CNT: begin
        if (fire && item_last) begin
          if (acc_next[63:32] > MAX_WORDS)  state_d = ERROR;
          else if (acc_next[63:32] == 32'd0) state_d = END_STATE;
          else                               state_d = DATA;
        end
      end
      DATA: if (fire && item_last && (word_idx_q + 32'd1 == count_q)) state_d = END_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (fire) state_d = (in_data == xsum_q) ? DRAIN : ERROR;
`endif
      DRAIN: state_d = RUN;
      default: state_d = state_q;
    endcase

    // Ready follows the next state so no byte slips in during DRAIN.
    case (state_d)
      HDR_PC, HDR_CNT, DATA: ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: ready_d = 1'b1;
`endif
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= HDR_PC;
      byte_cnt_q   <= 3'd0;
      word_idx_q   <= 32'd0;
      count_q      <= 32'd0;
      acc_q        <= 64'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xsum_q       <= 8'd0;
`endif
      in_ready     <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= 64'd0;
      imem_wr_data <= 32'd0;
      startpc      <= 64'd0;
      proc_resetl  <= 1'b0;
      busy         <= 1'b1;
      error        <= 1'b0;
      words_loaded <= 32'd0;
    end else begin
      state_q    <= state_d;
      in_ready   <= ready_d;
      imem_wr_en <= 1'b0;
      // Status lags the state by one register so the core sees release one
      // cycle after DRAIN has let the final write settle.
      proc_resetl <= (state_q == RUN);
      busy        <= !((state_q == RUN) || (state_q == ERROR));
      error       <= (state_q == ERROR);

      if (fire) begin
        acc_q      <= acc_next;
        byte_cnt_q <= item_last ? 3'd0 : byte_cnt_q + 3'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xsum_q     <= xsum_q ^ in_data;
`endif
        case (state_q)
          HDR_PC:  if (item_last) startpc <= acc_next;
          HDR_CNT: if (item_last) count_q <= acc_next[63:32];
          DATA: begin
            if (item_last) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= BASE_ADDR + {30'd0, word_idx_q, 2'b00};
              imem_wr_data <= acc_next[63:32];
              words_loaded <= word_idx_q + 32'd1;
              word_idx_q   <= word_idx_q + 32'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam int MAXW = 1024;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        imem_wr_en;
  logic [63:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic [63:0] startpc;
  logic        proc_resetl;
  logic        busy;
  logic        error;
  logic [31:0] words_loaded;

  imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(64'h0)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .startpc(startpc), .proc_resetl(proc_resetl),
    .busy(busy), .error(error), .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed write strobes and the edge count of every accepted byte.
  logic [63:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] wl_q[$];
  int          wc_q[$];
  int          edges[$];

  always @(negedge CLK) begin
    if (imem_wr_en === 1'b1) begin
      wa_q.push_back(imem_wr_addr);
      wd_q.push_back(imem_wr_data);
      wl_q.push_back(words_loaded);
      wc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    wa_q.delete(); wd_q.delete(); wl_q.delete(); wc_q.delete(); edges.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    clear_obs();
  endtask

  function automatic bq_t build_stream(input logic [63:0] pc, input int n, input wq_t w);
    bq_t s;
    logic [31:0] n32;
    n32 = n;
    for (int i = 0; i < 8; i++) s.push_back(pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) s.push_back(n32[8*i +: 8]);
    if (n <= MAXW)
      for (int k = 0; k < n; k++)
        for (int b = 0; b < 4; b++) s.push_back(w[k][8*b +: 8]);
    return s;
  endfunction

  // Bubbles: in_valid drops for one cycle before every byte but the first.
  task automatic send_stream(input bq_t s, input bit bubbles, output int last_edge);
    int t;
    last_edge = 0;
    foreach (s[j]) begin
      @(negedge CLK);
      if (bubbles && j != 0) begin
        in_valid = 1'b0;
        @(negedge CLK);
      end
      in_valid = 1'b1;
      in_data = s[j];
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge CLK);
        t++;
      end
      if (!in_ready) begin
        check("stream_ready_wait", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge CLK);
      #1;
      last_edge = cyc;
      edges.push_back(cyc);
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [63:0] pc, input int n,
                          input wq_t w, input bit bubbles, input bit corrupt);
    bq_t s;
    int  last_edge;
    int  i;
    int  nexp;
    bit  expect_err;
    s = build_stream(pc, n, w);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n <= MAXW) begin
      logic [7:0] x;
      x = 8'd0;
      foreach (s[j]) x ^= s[j];
      s.push_back(x ^ {7'd0, corrupt});
    end
`endif
    clear_obs();
    send_stream(s, bubbles, last_edge);
    expect_err = (n > MAXW) || corrupt;
    nexp = (n > MAXW) ? 0 : n;
    i = 0;
    @(negedge CLK);
    while (!(proc_resetl || error) && i < 20) begin
      @(negedge CLK);
      i++;
    end
    check({tag, ":finished"}, proc_resetl || error, 1'b1);
    if (!expect_err) check({tag, ":release_latency"}, cyc - last_edge, 2);
    repeat (3) @(negedge CLK);
    check({tag, ":error"}, error, expect_err);
    check({tag, ":proc_resetl"}, proc_resetl, !expect_err);
    check({tag, ":busy"}, busy, 1'b0);
    check({tag, ":in_ready"}, in_ready, 1'b0);
    check({tag, ":startpc"}, startpc, pc);
    check({tag, ":words_loaded"}, words_loaded, nexp);
    check({tag, ":write_count"}, wa_q.size(), nexp);
    for (int k = 0; k < wa_q.size() && k < nexp; k++) begin
      check($sformatf("%s:addr[%0d]", tag, k), wa_q[k], 64'(4 * k));
      check($sformatf("%s:data[%0d]", tag, k), wd_q[k], w[k]);
      check($sformatf("%s:count[%0d]", tag, k), wl_q[k], k + 1);
      check($sformatf("%s:wcycle[%0d]", tag, k), wc_q[k], edges[12 + 4*k + 3]);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wq_t w;
    bq_t s;
    int  le;

    // Reset values while reset is held.
    repeat (2) @(negedge CLK);
    check("rst:in_ready", in_ready, 1'b0);
    check("rst:wr_en", imem_wr_en, 1'b0);
    check("rst:wr_addr", imem_wr_addr, 64'd0);
    check("rst:wr_data", imem_wr_data, 32'd0);
    check("rst:startpc", startpc, 64'd0);
    check("rst:proc_resetl", proc_resetl, 1'b0);
    check("rst:busy", busy, 1'b1);
    check("rst:error", error, 1'b0);
    check("rst:words_loaded", words_loaded, 32'd0);
    reset = 1'b0;
    @(negedge CLK);
    check("rst:in_ready_after_release", in_ready, 1'b1);

    // Two words, back to back.
    w = '{32'hF84003E9, 32'h8B0A012B};
    run_load("two_words", 64'h100, 2, w, 1'b0, 1'b0);
    if (wc_q.size() == 2) check("two_words:spacing", wc_q[1] - wc_q[0], 4);

    do_reset();
    w = {};
    run_load("zero_words", 64'h40, 0, w, 1'b0, 1'b0);

    do_reset();
    run_load("too_many", 64'h1234, MAXW + 1, w, 1'b0, 1'b0);

    do_reset();
    w = '{32'hDEADBEEF};
    run_load("bubbles", 64'h2000, 1, w, 1'b1, 1'b0);

    // Abort mid-word, then reload.
    do_reset();
    w = '{32'hCAFEF00D};
    s = build_stream(64'h8000_0000_0000_0010, 1, w);
    while (s.size() > 14) void'(s.pop_back());
    send_stream(s, 1'b0, le);
    #2 reset = 1'b1;
    #1;
    check("abort:proc_resetl", proc_resetl, 1'b0);
    check("abort:busy", busy, 1'b1);
    check("abort:in_ready", in_ready, 1'b0);
    check("abort:startpc", startpc, 64'd0);
    @(negedge CLK);
    reset = 1'b0;
    w = '{$urandom, $urandom, $urandom};
    run_load("reload", {$urandom, $urandom}, 3, w, 1'b0, 1'b0);

    // Asynchronous reset out of RUN, away from any clock edge.
    #2 reset = 1'b1;
    #1;
    check("run_reset:proc_resetl", proc_resetl, 1'b0);
    check("run_reset:busy", busy, 1'b1);
    check("run_reset:words_loaded", words_loaded, 32'd0);

    for (int r = 0; r < 6; r++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 12);
      w = {};
      for (int k = 0; k < n; k++) w.push_back($urandom);
      run_load($sformatf("rand%0d", r), {$urandom, $urandom}, n, w, 1'($urandom), 1'b0);
    end

    // Largest accepted image.
    do_reset();
    w = {};
    for (int k = 0; k < MAXW; k++) w.push_back($urandom);
    run_load("max_words", 64'hFFFF_0000_0000_0004, MAXW, w, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    w = '{$urandom, $urandom};
    run_load("bad_checksum", 64'h300, 2, w, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
